// File: rtl/moving_platform.sv
// Moving platform sprite: one W x H block that travels a fixed distance along
// one axis, driven by trigger inputs in hold, toggle or auto ping-pong mode.
// Produces position, per-step carry delta and sprite hit/ROM address.
module moving_platform #(
  parameter int START_X   = 23,
  parameter int START_Y   = 256,
  parameter int AXIS      = 1,
  parameter int TRAVEL    = 47,
  parameter int SPEED     = 1,
  parameter int FRAME_DIV = 4,
  parameter int MODE      = 0,
  parameter int DWELL     = 30,
  parameter int NTRIG     = 2,
  parameter int W         = 64,
  parameter int H         = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_clk,
  input  logic [NTRIG-1:0]    trig,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  output logic signed [15:0]  pos_x,
  output logic signed [15:0]  pos_y,
  output logic signed [15:0]  delta,
  output logic                step_pulse,
  output logic [1:0]          state,
  output logic                active,
  output logic                is_platform,
  output logic [9:0]          read_addr
);

  typedef enum logic [1:0] {
    AT_START = 2'd0,
    FWD      = 2'd1,
    AT_END   = 2'd2,
    BACK     = 2'd3
  } state_t;

  localparam bit                 NEG        = (TRAVEL < 0);
  localparam logic signed [15:0] TRAVEL_MAG = 16'(NEG ? -TRAVEL : TRAVEL);
  localparam logic signed [15:0] SPEED_S    = 16'(SPEED);
  localparam logic signed [15:0] START_AX   = (AXIS == 0) ? 16'(START_X) : 16'(START_Y);
  localparam logic [15:0]        DIV_LAST   = 16'(FRAME_DIV - 1);
  localparam logic [15:0]        DWELL_U    = 16'(DWELL);
  localparam logic signed [15:0] W_S        = 16'(W);
  localparam logic signed [15:0] H_S        = 16'(H);
  localparam logic [9:0]         W_A        = 10'(W);

  // Step size limited so the platform never overshoots the end it approaches.
  function automatic logic signed [15:0] clamp_step(input logic signed [15:0] rem);
    return (rem < SPEED_S) ? rem : SPEED_S;
  endfunction

  // Signed axis displacement for a step magnitude in the given direction.
  function automatic logic signed [15:0] signed_step(input logic signed [15:0] mag,
                                                     input logic toward_end);
    return (toward_end ^ NEG) ? mag : -mag;
  endfunction

  state_t             st_q;
  state_t             nxt_st;
  logic               frame_p0, frame_p1, frame_p2;
  logic               frame_edge;
  logic [15:0]        div_q;
  logic               tick;
  logic               trig_any, trig_d, tog_q;
  logic [15:0]        dwell_q;
  logic               dwell_done;
  logic               req;
  logic               freeze;
  logic signed [15:0] prog_q, prog_nxt;
  logic signed [15:0] rem_end, rem_start;
  logic signed [15:0] mv;
  logic               toward_end;
  logic signed [15:0] axis_nxt;
  logic signed [15:0] rel_x, rel_y;

  assign state      = st_q;
  assign trig_any   = |trig;
  assign dwell_done = (dwell_q == DWELL_U);
  assign freeze     = (MODE == 2) && trig_any;
  assign rem_end    = TRAVEL_MAG - prog_q;
  assign rem_start  = prog_q;

  // frame_clk crosses into Clk through two flops; third flop gives edge detect.
  always_ff @(posedge Clk) begin
    frame_p0 <= frame_clk;
    frame_p1 <= frame_p0;
    frame_p2 <= frame_p1;
  end

  assign frame_edge = frame_p1 & ~frame_p2;
  assign tick       = frame_edge && (div_q == DIV_LAST);

  // Frame edge divider: one movement tick every FRAME_DIV frames.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q <= '0;
    end else if (frame_edge) begin
      div_q <= (div_q == DIV_LAST) ? 16'd0 : div_q + 16'd1;
    end
  end

  // Toggle-mode request flips on each rising edge of the OR'ed triggers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      trig_d <= 1'b0;
      tog_q  <= 1'b0;
    end else begin
      trig_d <= trig_any;
      if (trig_any && !trig_d) tog_q <= ~tog_q;
    end
  end

  // Request level: direct, toggled, or generated from the auto dwell schedule.
  always_comb begin
    req = 1'b0;
    if (MODE == 0) begin
      req = trig_any;
    end else if (MODE == 1) begin
      req = tog_q;
    end else begin
      unique case (st_q)
        AT_START: req = dwell_done;
        FWD:      req = 1'b1;
        AT_END:   req = !dwell_done;
        BACK:     req = 1'b0;
      endcase
    end
  end

  // Next state and step magnitude; arriving at an end parks there the same tick.
  always_comb begin
    nxt_st     = st_q;
    mv         = 16'sd0;
    toward_end = 1'b1;
    unique case (st_q)
      AT_START: begin
        if (req) nxt_st = (TRAVEL_MAG == 16'sd0) ? AT_END : FWD;
      end
      AT_END: begin
        if (!req) nxt_st = (TRAVEL_MAG == 16'sd0) ? AT_START : BACK;
      end
      FWD, BACK: begin
        if (req) begin
          mv     = clamp_step(rem_end);
          nxt_st = (rem_end <= SPEED_S) ? AT_END : FWD;
        end else begin
          toward_end = 1'b0;
          mv         = clamp_step(rem_start);
          nxt_st     = (rem_start <= SPEED_S) ? AT_START : BACK;
        end
      end
    endcase
  end

  assign prog_nxt = toward_end ? (prog_q + mv) : (prog_q - mv);
  assign axis_nxt = NEG ? (START_AX - prog_nxt) : (START_AX + prog_nxt);

  // Position, delta, state and dwell update together on each unfrozen tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      st_q       <= AT_START;
      prog_q     <= 16'sd0;
      pos_x      <= 16'(START_X);
      pos_y      <= 16'(START_Y);
      delta      <= 16'sd0;
      step_pulse <= 1'b0;
      active     <= 1'b0;
      dwell_q    <= '0;
    end else begin
      step_pulse <= tick;
      active     <= req;
      if (tick) begin
        if (freeze) begin
          delta <= 16'sd0;
        end else begin
          st_q   <= nxt_st;
          prog_q <= prog_nxt;
          delta  <= signed_step(mv, toward_end);
          if (AXIS == 0) pos_x <= axis_nxt;
          else           pos_y <= axis_nxt;
          if ((MODE == 2) && ((st_q == AT_START) || (st_q == AT_END)) && (nxt_st == st_q))
            dwell_q <= dwell_q + 16'd1;
          else
            dwell_q <= '0;
        end
      end
    end
  end

  // Sprite hit test and ROM address for the current pixel, signed so that
  // off-screen positions never alias into a hit.
  always_comb begin
    rel_x       = $signed({6'd0, DrawX}) - pos_x;
    rel_y       = $signed({6'd0, DrawY}) - pos_y;
    is_platform = (rel_x >= 16'sd0) && (rel_x < W_S) && (rel_y >= 16'sd0) && (rel_y < H_S);
    read_addr   = is_platform ? (rel_y[9:0] * W_A + rel_x[9:0]) : 10'd0;
  end

endmodule

// File: tb/tb_moving_platform.sv
// Directed bench for moving_platform: four instances (hold, fast hold,
// toggle, auto) share clock, reset and frame clock; expected tick results
// are queued as stimulus is issued and compared on each step_pulse.
module tb_moving_platform;

  localparam logic [1:0] S_START = 2'd0, S_FWD = 2'd1, S_END = 2'd2, S_BACK = 2'd3;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic frame_clk = 1'b0;
  logic [1:0] trig [4];
  logic [9:0] DrawX = 10'd0;
  logic [9:0] DrawY = 10'd0;
  logic signed [15:0] px [4];
  logic signed [15:0] py [4];
  logic signed [15:0] dl [4];
  logic [1:0] st [4];
  logic sp [4];
  logic act [4];
  logic hit [4];
  logic [9:0] ra [4];

  int n_assert = 0;
  int n_fail = 0;
  int sel = 0;
  int sb_id = 0;
  int fedges = 0;
  int last_fe = 0;

  typedef struct packed {
    logic [15:0]        id;
    logic signed [15:0] px;
    logic signed [15:0] py;
    logic signed [15:0] dl;
    logic [1:0]         st;
  } exp_t;

  exp_t sbq[$];

  always #5 Clk = ~Clk;

  always @(posedge frame_clk) fedges++;

  moving_platform u_hold (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .trig(trig[0]),
    .DrawX(DrawX), .DrawY(DrawY), .pos_x(px[0]), .pos_y(py[0]), .delta(dl[0]),
    .step_pulse(sp[0]), .state(st[0]), .active(act[0]),
    .is_platform(hit[0]), .read_addr(ra[0]));

  moving_platform #(.SPEED(5)) u_fast (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .trig(trig[1]),
    .DrawX(DrawX), .DrawY(DrawY), .pos_x(px[1]), .pos_y(py[1]), .delta(dl[1]),
    .step_pulse(sp[1]), .state(st[1]), .active(act[1]),
    .is_platform(hit[1]), .read_addr(ra[1]));

  moving_platform #(.MODE(1)) u_tog (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .trig(trig[2]),
    .DrawX(DrawX), .DrawY(DrawY), .pos_x(px[2]), .pos_y(py[2]), .delta(dl[2]),
    .step_pulse(sp[2]), .state(st[2]), .active(act[2]),
    .is_platform(hit[2]), .read_addr(ra[2]));

  moving_platform #(.MODE(2), .DWELL(2), .TRAVEL(-3)) u_auto (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .trig(trig[3]),
    .DrawX(DrawX), .DrawY(DrawY), .pos_x(px[3]), .pos_y(py[3]), .delta(dl[3]),
    .step_pulse(sp[3]), .state(st[3]), .active(act[3]),
    .is_platform(hit[3]), .read_addr(ra[3]));

  // Scoreboard monitor: on every step pulse of the selected instance, check
  // the frame-edge spacing and pop the expected post-tick state.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset) begin
      last_fe = fedges;
    end else if (sp[sel]) begin
      n_assert++;
      assert (fedges - last_fe === 4) else begin
        n_fail++;
        $error("FAIL edges_per_tick observed=%0d expected=4", fedges - last_fe);
      end
      last_fe = fedges;
      n_assert++;
      assert (sbq.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_underflow observed=unexpected step_pulse expected=none");
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        n_assert++;
        assert ({px[sel], py[sel], dl[sel], st[sel]} === {e.px, e.py, e.dl, e.st}) else begin
          n_fail++;
          $error("FAIL sb#%0d observed=(x%0d,y%0d,d%0d,s%0d) expected=(x%0d,y%0d,d%0d,s%0d)",
                 e.id, px[sel], py[sel], dl[sel], st[sel], e.px, e.py, e.dl, e.st);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  task automatic do_tick();
    repeat (4) begin
      frame_clk = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      frame_clk = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
    end
  endtask

  // Queue the expected result of one tick, then produce that tick.
  task automatic step(input int y, input int d, input logic [1:0] s);
    exp_t e;
    e.id = 16'(sb_id);
    e.px = 16'sd23;
    e.py = 16'(y);
    e.dl = 16'(d);
    e.st = s;
    sb_id++;
    sbq.push_back(e);
    do_tick();
  endtask

  task automatic reset_dut();
    @(posedge Clk); #1;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  task automatic pulse_trig(input int idx);
    @(posedge Clk); #1;
    trig[idx] = 2'b10;
    @(posedge Clk); #1;
    trig[idx] = 2'b00;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) trig[i] = 2'b00;
    Reset = 1'b1;
    repeat (4) @(posedge Clk);
    #1;

    // Reset state
    check("rst_pos_x", 32'(px[0]), 32'(23));
    check("rst_pos_y", 32'(py[0]), 32'(256));
    check("rst_delta", 32'(dl[0]), 32'(0));
    check("rst_state", 32'(st[0]), 32'(S_START));
    check("rst_step_pulse", 32'(sp[0]), 32'(0));
    check("rst_active", 32'(act[0]), 32'(0));
    Reset = 1'b0;

    // T1: hold mode full travel, then holding at the end
    sel = 0;
    trig[0] = 2'b01;
    step(256, 0, S_FWD);
    for (int k = 1; k <= 47; k++) step(256 + k, 1, (k == 47) ? S_END : S_FWD);
    step(303, 0, S_END);
    check("t1_active", 32'(act[0]), 32'(1));
    check("t1_sb_empty", 32'(sbq.size()), 32'(0));

    // T3: trigger released mid-travel reverses and returns to start
    reset_dut();
    step(256, 0, S_FWD);
    for (int k = 1; k <= 14; k++) step(256 + k, 1, S_FWD);
    trig[0] = 2'b00;
    step(269, -1, S_BACK);
    for (int j = 1; j <= 13; j++) step(269 - j, -1, (j == 13) ? S_START : S_BACK);
    check("t3_active", 32'(act[0]), 32'(0));
    check("t3_sb_empty", 32'(sbq.size()), 32'(0));

    // T2: SPEED=5 clamps the final step to the remaining 2 px
    sel = 1;
    reset_dut();
    trig[1] = 2'b01;
    step(256, 0, S_FWD);
    for (int k = 1; k <= 9; k++) step(256 + 5 * k, 5, S_FWD);
    step(303, 2, S_END);
    trig[1] = 2'b00;
    check("t2_sb_empty", 32'(sbq.size()), 32'(0));

    // T4: toggle mode, single-cycle pulses start, reverse at end, reverse mid-way
    sel = 2;
    reset_dut();
    pulse_trig(2);
    check("t4_active_on", 32'(act[2]), 32'(1));
    step(256, 0, S_FWD);
    for (int k = 1; k <= 47; k++) step(256 + k, 1, (k == 47) ? S_END : S_FWD);
    pulse_trig(2);
    check("t4_active_off", 32'(act[2]), 32'(0));
    step(303, 0, S_BACK);
    for (int j = 1; j <= 23; j++) step(303 - j, -1, S_BACK);
    pulse_trig(2);
    step(281, 1, S_FWD);
    check("t4_sb_empty", 32'(sbq.size()), 32'(0));

    // T5: auto ping-pong with dwell 2 over -3 px, then freeze and resume
    sel = 3;
    reset_dut();
    step(256, 0, S_START);
    step(256, 0, S_START);
    step(256, 0, S_FWD);
    step(255, -1, S_FWD);
    step(254, -1, S_FWD);
    step(253, -1, S_END);
    step(253, 0, S_END);
    step(253, 0, S_END);
    step(253, 0, S_BACK);
    step(254, 1, S_BACK);
    step(255, 1, S_BACK);
    step(256, 1, S_START);
    step(256, 0, S_START);
    step(256, 0, S_START);
    step(256, 0, S_FWD);
    step(255, -1, S_FWD);
    trig[3] = 2'b01;
    step(255, 0, S_FWD);
    step(255, 0, S_FWD);
    trig[3] = 2'b00;
    step(254, -1, S_FWD);
    step(253, -1, S_END);
    check("t5_sb_empty", 32'(sbq.size()), 32'(0));

    // T6: pixel hit/address at the start position, then reset teleport
    sel = 0;
    reset_dut();
    DrawX = 10'd86; DrawY = 10'd271; #1;
    check("t6_hit_corner", 32'(hit[0]), 32'(1));
    check("t6_addr_corner", 32'(ra[0]), 32'(1023));
    DrawX = 10'd87; #1;
    check("t6_miss_right", 32'(hit[0]), 32'(0));
    check("t6_addr_miss", 32'(ra[0]), 32'(0));
    DrawX = 10'd23; DrawY = 10'd256; #1;
    check("t6_hit_origin", 32'(hit[0]), 32'(1));
    check("t6_addr_origin", 32'(ra[0]), 32'(0));
    DrawX = 10'd22; #1;
    check("t6_miss_left", 32'(hit[0]), 32'(0));
    DrawX = 10'd40; DrawY = 10'd272; #1;
    check("t6_miss_below", 32'(hit[0]), 32'(0));
    DrawX = 10'd40; DrawY = 10'd258; #1;
    check("t6_addr_mid", 32'(ra[0]), 32'(2 * 64 + 17));

    trig[0] = 2'b01;
    step(256, 0, S_FWD);
    for (int k = 1; k <= 34; k++) step(256 + k, 1, S_FWD);
    check("t6_pre_reset_y", 32'(py[0]), 32'(290));
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("t6_reset_y", 32'(py[0]), 32'(256));
    check("t6_reset_delta", 32'(dl[0]), 32'(0));
    check("t6_reset_state", 32'(st[0]), 32'(S_START));
    Reset = 1'b0;
    trig[0] = 2'b00;
    check("t6_sb_empty", 32'(sbq.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
